// File: rtl/adder_cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake and whole-pipe stall.
// Optional signed-overflow output ovf_o is enabled by defining ADDER_CLA_PIPE_OVF_EN.
module adder_cla_pipe #(
   parameter int BW_DATA = 32,
   parameter int NSTAGE  = 4,
   parameter int BW_GRP  = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [BW_DATA-1:0] A_i,
   input  logic [BW_DATA-1:0] B_i,
   input  logic               Cin,
   input  logic               sub_i,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [BW_DATA-1:0] S_o,
   output logic               Cout_o
`ifdef ADDER_CLA_PIPE_OVF_EN
   ,
   output logic               ovf_o
`endif
);

   localparam int W    = BW_DATA / NSTAGE;
   localparam int NGRP = W / BW_GRP;
   localparam int MSB  = BW_DATA - 1;

   // Rank 0 holds conditioned operands; rank r (1..NSTAGE) holds the result of stage r-1.
   logic               en;
   logic [NSTAGE:0]    vld_reg;
   logic [NSTAGE:0]    c_reg;
   logic [BW_DATA-1:0] a_reg  [0:NSTAGE-1];
   logic [BW_DATA-1:0] b_reg  [0:NSTAGE-1];
   logic [BW_DATA-1:0] s_reg  [0:NSTAGE];
   logic [BW_DATA-1:0] s_next [0:NSTAGE-1];
   logic [BW_DATA-1:0] sum_all;
   logic [NSTAGE-1:0]  cout_all;
   logic [BW_DATA-1:0] b_eff;
   logic               c0;

   // Carry into position lo+n given carry cin into position lo, in flat sum-of-products form
   // so no carry term depends on another computed carry.
   function automatic logic cla_carry(input logic [W-1:0] g, input logic [W-1:0] p,
                                      input logic cin, input int lo, input int n);
      logic c;
      logic t;
      c = 1'b0;
      for (int i = -1; i < n; i++) begin
         if (i < 0) t = cin;
         else       t = g[lo+i];
         for (int m = i + 1; m < n; m++) t = t & p[lo+m];
         c = c | t;
      end
      return c;
   endfunction

   assign b_eff   = sub_i ? ~B_i : B_i;
   assign c0      = sub_i | Cin;
   assign en      = ~vld_reg[NSTAGE] | ready_i;
   assign ready_o = en;
   assign valid_o = vld_reg[NSTAGE];
   assign S_o     = s_reg[NSTAGE];
   assign Cout_o  = c_reg[NSTAGE];

   genvar gi;
   generate
      for (gi = 0; gi < NSTAGE; gi++) begin : g_stage
         logic [W-1:0]  a_sl;
         logic [W-1:0]  b_sl;
         logic [W-1:0]  g_bit;
         logic [W-1:0]  p_bit;
         logic [W-1:0]  c_bit;
         logic [W-1:0]  g_grp;  // low NGRP bits used; padded to share cla_carry
         logic [W-1:0]  p_grp;
         logic [NGRP:0] c_grp;

         assign a_sl  = a_reg[gi][gi*W +: W];
         assign b_sl  = b_reg[gi][gi*W +: W];
         assign g_bit = a_sl & b_sl;
         assign p_bit = a_sl ^ b_sl;

         always_comb begin
            g_grp = '0;
            p_grp = '0;
            for (int j = 0; j < NGRP; j++) begin
               g_grp[j] = cla_carry(g_bit, p_bit, 1'b0, j*BW_GRP, BW_GRP);
               p_grp[j] = &p_bit[j*BW_GRP +: BW_GRP];
            end
         end

         always_comb begin
            c_grp = '0;
            for (int j = 0; j <= NGRP; j++)
               c_grp[j] = cla_carry(g_grp, p_grp, c_reg[gi], 0, j);
         end

         always_comb begin
            c_bit = '0;
            for (int j = 0; j < NGRP; j++)
               for (int b = 0; b < BW_GRP; b++)
                  c_bit[j*BW_GRP+b] = cla_carry(g_bit, p_bit, c_grp[j], j*BW_GRP, b);
         end

         assign sum_all[gi*W +: W] = p_bit ^ c_bit;
         assign cout_all[gi]       = c_grp[NGRP];
      end
   endgenerate

   always_comb begin
      for (int r = 0; r < NSTAGE; r++) begin
         s_next[r]            = s_reg[r];
         s_next[r][r*W +: W]  = sum_all[r*W +: W];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_reg <= '0;
         c_reg   <= '0;
         for (int r = 0; r < NSTAGE; r++) begin
            a_reg[r] <= '0;
            b_reg[r] <= '0;
         end
         for (int r = 0; r <= NSTAGE; r++) s_reg[r] <= '0;
      end else if (en) begin
         // Bubbles advance with their (don't-care) data; nothing collapses.
         vld_reg  <= {vld_reg[NSTAGE-1:0], valid_i};
         c_reg    <= {cout_all, c0};
         a_reg[0] <= A_i;
         b_reg[0] <= b_eff;
         s_reg[0] <= '0;
         for (int r = 1; r < NSTAGE; r++) begin
            a_reg[r] <= a_reg[r-1];
            b_reg[r] <= b_reg[r-1];
         end
         for (int r = 1; r <= NSTAGE; r++) s_reg[r] <= s_next[r-1];
      end
   end

`ifdef ADDER_CLA_PIPE_OVF_EN
   logic ovf_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ovf_reg <= 1'b0;
      end else if (en) begin
         ovf_reg <= (a_reg[NSTAGE-1][MSB] == b_reg[NSTAGE-1][MSB]) &
                    (sum_all[MSB] != a_reg[NSTAGE-1][MSB]);
      end
   end

   assign ovf_o = ovf_reg;
`endif

endmodule

// File: tb/tb_adder_cla_pipe.sv
// Scoreboard bench for adder_cla_pipe: directed vectors with hand-computed results,
// accept-side push and output-side pop/compare in a negedge monitor.
module tb_adder_cla_pipe;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] A_i;
   logic [31:0] B_i;
   logic        Cin;
   logic        sub_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] S_o;
   logic        Cout_o;
`ifdef ADDER_CLA_PIPE_OVF_EN
   logic        ovf_o;
`endif

   always #5 clk = ~clk;

   adder_cla_pipe #(.BW_DATA(32), .NSTAGE(4), .BW_GRP(4)) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .A_i     (A_i),
      .B_i     (B_i),
      .Cin     (Cin),
      .sub_i   (sub_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .S_o     (S_o),
      .Cout_o  (Cout_o)
`ifdef ADDER_CLA_PIPE_OVF_EN
      , .ovf_o (ovf_o)
`endif
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] s;
      logic        c;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [31:0] s;
      logic        c;
      logic        ovf;
      int          acc;
      bit          lat;
   } exp_t;

   vec_t        tv [0:13];
   exp_t        sb [$];
   logic [31:0] exp_s;
   logic        exp_c;
   logic        exp_ovf;
   bit          lat_chk;
   int          cyc = 0;
   int          n_pass = 0;
   int          n_tot = 0;
   int          n_retire = 0;
   bit          held = 1'b0;
   logic [31:0] held_s;
   logic        held_c;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      else             n_pass++;
   endtask

   // Monitor: retire/compare first, then record any acceptance for the coming edge.
   always @(negedge clk) begin
      exp_t e;
      if (rst_i) begin
         sb.delete();
         held = 1'b0;
      end else begin
         if (held) begin
            chk("stall_valid_o", valid_o, 1);
            chk("stall_S_o", S_o, held_s);
            chk("stall_Cout_o", Cout_o, held_c);
         end
         if (valid_o && ready_i) begin
            n_retire++;
            if (sb.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("S_o", S_o, e.s);
               chk("Cout_o", Cout_o, e.c);
`ifdef ADDER_CLA_PIPE_OVF_EN
               chk("ovf_o", ovf_o, e.ovf);
`endif
               if (e.lat) chk("latency", cyc - e.acc - 1, 4);
            end
         end
         held   = valid_o && !ready_i;
         held_s = S_o;
         held_c = Cout_o;
         if (valid_i && ready_o) begin
            e.s   = exp_s;
            e.c   = exp_c;
            e.ovf = exp_ovf;
            e.acc = cyc;
            e.lat = lat_chk;
            sb.push_back(e);
         end
      end
   end

   task automatic send(input int i, input bit lat);
      bit ok;
      ok      = 1'b0;
      A_i     = tv[i].a;
      B_i     = tv[i].b;
      Cin     = tv[i].cin;
      sub_i   = tv[i].sub;
      exp_s   = tv[i].s;
      exp_c   = tv[i].c;
      exp_ovf = tv[i].ovf;
      lat_chk = lat;
      valid_i = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (ready_o) begin
            ok = 1'b1;
            break;
         end
      end
      chk("accept_in_time", ok, 1);
      @(posedge clk);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && sb.size() != 0; k++) begin
         @(negedge clk);
         #1;
      end
      chk("drain_pending", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int snap;
      tv[0]  = '{a:32'hFFFF_FFFF, b:32'h0000_0001, cin:1'b0, sub:1'b0, s:32'h0000_0000, c:1'b1, ovf:1'b0};
      tv[1]  = '{a:32'h0000_0007, b:32'h0000_0005, cin:1'b1, sub:1'b1, s:32'h0000_0002, c:1'b1, ovf:1'b0};
      tv[2]  = '{a:32'h0000_0005, b:32'h0000_0007, cin:1'b1, sub:1'b1, s:32'hFFFF_FFFE, c:1'b0, ovf:1'b0};
      tv[3]  = '{a:32'h8000_0000, b:32'h0000_0001, cin:1'b1, sub:1'b1, s:32'h7FFF_FFFF, c:1'b1, ovf:1'b1};
      tv[4]  = '{a:32'h0000_0000, b:32'h0000_0000, cin:1'b0, sub:1'b0, s:32'h0000_0000, c:1'b0, ovf:1'b0};
      tv[5]  = '{a:32'h0000_0000, b:32'h0000_0000, cin:1'b1, sub:1'b0, s:32'h0000_0001, c:1'b0, ovf:1'b0};
      tv[6]  = '{a:32'h1234_5678, b:32'h1111_1111, cin:1'b0, sub:1'b0, s:32'h2345_6789, c:1'b0, ovf:1'b0};
      tv[7]  = '{a:32'h0000_FFFF, b:32'h0000_0001, cin:1'b0, sub:1'b0, s:32'h0001_0000, c:1'b0, ovf:1'b0};
      tv[8]  = '{a:32'h0000_00FF, b:32'h0000_0001, cin:1'b0, sub:1'b0, s:32'h0000_0100, c:1'b0, ovf:1'b0};
      tv[9]  = '{a:32'h7FFF_FFFF, b:32'h0000_0001, cin:1'b0, sub:1'b0, s:32'h8000_0000, c:1'b0, ovf:1'b1};
      tv[10] = '{a:32'hFFFF_FFFF, b:32'hFFFF_FFFF, cin:1'b1, sub:1'b0, s:32'hFFFF_FFFF, c:1'b1, ovf:1'b0};
      tv[11] = '{a:32'h0000_0000, b:32'h0000_0001, cin:1'b0, sub:1'b1, s:32'hFFFF_FFFF, c:1'b0, ovf:1'b0};
      tv[12] = '{a:32'h0000_0010, b:32'h0000_0010, cin:1'b0, sub:1'b1, s:32'h0000_0000, c:1'b1, ovf:1'b0};
      tv[13] = '{a:32'hAAAA_AAAA, b:32'h5555_5555, cin:1'b1, sub:1'b0, s:32'h0000_0000, c:1'b1, ovf:1'b0};

      // Reset with valid_i high: nothing may be accepted.
      rst_i   = 1'b1;
      valid_i = 1'b1;
      ready_i = 1'b1;
      A_i     = 32'h1234_5678;
      B_i     = 32'h0000_0001;
      Cin     = 1'b0;
      sub_i   = 1'b0;
      exp_s   = '0;
      exp_c   = 1'b0;
      exp_ovf = 1'b0;
      lat_chk = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_i   = 1'b0;
      valid_i = 1'b0;
      chk("reset_valid_o", valid_o, 0);
      chk("reset_S_o", S_o, 0);
      chk("reset_Cout_o", Cout_o, 0);
      chk("reset_ready_o", ready_o, 1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("post_reset_no_output", valid_o, 0);
      end
      @(posedge clk);
      #1;

      // Carry through every stage.
      send(0, 1'b1);
      drain();

      // Subtract mode, Cin ignored.
      for (int i = 1; i <= 3; i++) send(i, 1'b1);
      drain();

      // Back-to-back streaming.
      for (int i = 4; i <= 13; i++) send(i, 1'b1);
      drain();

      // Backpressure on a full pipe.
      fork
         begin
            for (int i = 4; i < 12; i++) send(i, 1'b0);
         end
         begin
            for (int k = 0; k < 40 && !valid_o; k++) @(negedge clk);
            @(posedge clk);
            #1;
            ready_i = 1'b0;
            repeat (3) begin
               @(negedge clk);
               chk("bp_ready_o", ready_o, 0);
            end
            @(posedge clk);
            #1;
            ready_i = 1'b1;
         end
      join
      drain();

      // Reset with three operations in flight.
      send(5, 1'b0);
      send(6, 1'b0);
      send(7, 1'b0);
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      chk("midrst_valid_o", valid_o, 0);
      chk("midrst_S_o", S_o, 0);
      chk("midrst_Cout_o", Cout_o, 0);
      chk("midrst_ready_o", ready_o, 1);
      snap = n_retire;
      repeat (8) @(negedge clk);
      chk("midrst_no_ghost", n_retire - snap, 0);
      @(posedge clk);
      #1;

      // Pipe still works after the flush.
      send(13, 1'b1);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish before 200000");
      $fatal(1);
   end

endmodule

// File: doc/adder_cla_pipe.md
Name: adder_cla_pipe

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the single-cycle 32-bit CLA adder.
- Operand width, pipeline depth and CLA group size are configurable.
- Adds an add/subtract mode and a valid/ready handshake with backpressure.
- Used as the arithmetic core in datapaths that need full clock rate at widths where a single-cycle CLA misses timing.

Parameters:
BW_DATA, 32, operand/result width in bits
NSTAGE, 4, pipeline stages; must divide BW_DATA; each stage resolves BW_DATA/NSTAGE bits
BW_GRP, 4, CLA group width inside a stage; must divide BW_DATA/NSTAGE

Ports:
clk_i     input   1          clock, all logic on rising edge
rst_i     input   1          synchronous reset, active-high
valid_i   input   1          input operands valid
ready_o   output  1          block accepts operands this cycle
A_i       input   BW_DATA    operand A
B_i       input   BW_DATA    operand B
Cin       input   1          carry-in (add mode only)
sub_i     input   1          0: A+B+Cin; 1: A-B (two's complement)
valid_o   output  1          result valid
ready_i   input   1          downstream accepts result
S_o       output  BW_DATA    sum/difference
Cout_o    output  1          carry-out of MSB (in sub mode: 1 = no borrow)

Behaviour:
Reset:
- rst_i sampled high on a rising edge clears all stage valid bits, data registers and carry registers to 0.
- Next cycle: valid_o=0, S_o=0, Cout_o=0, ready_o=1.
- Reset overrides any handshake in the same cycle. Reset mid-operation discards every in-flight operation.

Operand conditioning (combinational, before stage 0):
- B_eff = sub_i ? ~B_i : B_i
- c0 = sub_i ? 1 : Cin; Cin is ignored in sub mode.

Stage k (0..NSTAGE-1):
- Computes bits [k*W +: W], W = BW_DATA/NSTAGE, from its operand slice and the carry registered by stage k-1 (c0 for stage 0).
- Uses BW_GRP-bit generate/propagate groups with group-level lookahead.
- No ripple across group boundaries inside a stage.
- Pipeline is skewed:
  - operand slices for later stages are delayed through registers;
  - result slices from earlier stages are delayed to stay aligned.
- The final stage registers S_o (all slices) and Cout_o together.

Latency and throughput:
- Exactly NSTAGE cycles from the accepting edge to valid_o=1 when not stalled.
- Throughput 1 result/cycle.

Handshake:
- en = ~valid_o | ready_i; ready_o = en (combinational).
- Input accepted on a rising edge with valid_i & ready_o.
- When en=0 the whole pipeline holds: every register, including stage valids, keeps its value.
- When en=1 all stages advance together. Bubbles (valid=0 stages) advance but do not collapse.
- valid_o, S_o and Cout_o stay stable while valid_o=1 & ready_i=0.
- Results emerge in acceptance order. No drop, no duplication.

Arithmetic:
- Modulo 2^BW_DATA; {Cout_o, S_o} = A + B_eff + c0.
- Wrap-around is silent apart from Cout_o.

Simultaneous events:
- An input accept and an output retire in the same cycle are both honoured.
- valid_i is ignored when ready_o=0; the operands must be held by the source.

Optional Feature:
Macro ADDER_CLA_PIPE_OVF_EN.
- Defined:
  - Adds output port ovf_o (1 bit) = signed two's-complement overflow of the operation: (A[MSB]==B_eff[MSB]) & (S[MSB]!=A[MSB]).
  - Registered and aligned with S_o; held under stall; reset to 0.
- Undefined: port and its logic absent; everything else identical.

Test Plan:
Defaults BW_DATA=32, NSTAGE=4, BW_GRP=4.
1. Reset: rst_i=1 for 2 cycles with valid_i=1 -> valid_o=0, S_o=0, Cout_o=0, ready_o=1 after release; no spurious output within 4 cycles.
2. Carry across all stages: add 0xFFFF_FFFF+0x0000_0001, Cin=0 -> exactly 4 cycles later valid_o=1, S_o=0x0000_0000, Cout_o=1; with OVF_EN, ovf_o=0.
3. Subtract, sub_i=1, Cin=1 (ignored): 7-5 -> S_o=0x0000_0002, Cout_o=1. Then 5-7 -> S_o=0xFFFF_FFFE, Cout_o=0. Then 0x8000_0000-1 -> S_o=0x7FFF_FFFF, ovf_o=1 when enabled.
4. Streaming: 10 file-loaded vectors on consecutive cycles with ready_i=1 -> 10 consecutive valid_o cycles starting at cycle 4, in order, all matching golden o_s/o_c.
5. Backpressure: fill the pipe, hold ready_i=0 for 3 cycles -> ready_o=0, outputs frozen. On release, remaining results appear one per cycle in order, none lost or repeated.
6. Reset mid-stream: assert rst_i while 3 operations are in flight -> valid_o=0 the next cycle, and none of the 3 results ever appears.
